fetch_queue: RTL and testbench

Instruction fetch and buffering stage that sits directly upstream of the decoders in the dual-issue core. It generates fetch addresses, issues 64-bit requests to a synchronous instruction memory, and enqueues the returned instruction/PC pairs in a circular queue. It presents the two oldest entries to the decode slots every cycle. On a branch redirect it flushes the queue and squashes any in-flight fetch.

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch + buffering stage ahead of the dual-issue decoders.
//   Generates 8-byte aligned fetch requests, takes the 64-bit response one
//   cycle later, and enqueues the instruction/PC pairs into a circular queue.
//   The two oldest entries are presented to the decode slots every cycle.
//   A redirect flushes the queue, drops any in-flight response and restarts
//   fetch at the new PC.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   redirect_i/redirect_pc_i flush + new fetch PC (bits [1:0] ignored)
//   imem_req_o/imem_addr_o  fetch request and 8-byte aligned address
//   imem_data_i             response, valid the cycle after a request
//   issue_cnt_i             entries consumed by decode this cycle (0..2)
//   inst0/1_o, pc0/1_o      oldest / second-oldest entry (NOP / 0 if invalid)
//   valid0/1_o              count >= 1 / count >= 2
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [63:0] imem_data_i,
    input  logic [1:0]  issue_cnt_i,
    output logic [31:0] inst0_o,
    output logic [31:0] inst1_o,
    output logic [31:0] pc0_o,
    output logic [31:0] pc1_o,
    output logic        valid0_o,
    output logic        valid1_o
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH - 2);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

    fq_entry_t         q_mem [DEPTH];
    logic [31:0]       fpc, pend_pc;
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic              pend;

    logic [CW:0]       occ;
    logic [1:0]        enq_n, deq_n;
    fq_entry_t         wr0, wr1;

    // Occupancy counts the in-flight response as two slots, and ignores this
    // cycle's dequeue, so a request can never overflow the queue.
    assign occ         = {1'b0, count} + {{(CW-1){1'b0}}, pend, 1'b0};
    assign imem_req_o  = !rst_i && !redirect_i && (occ <= OCC_MAX);
    assign imem_addr_o = {fpc[31:3], 3'b000};

    always_comb begin
        enq_n = 2'd0;
        wr0   = '0;
        wr1   = '0;
        if (pend) begin
            if (pend_pc[2]) begin
                // Fetch started mid-doubleword: only the upper word is wanted.
                enq_n = 2'd1;
                wr0   = '{inst: imem_data_i[63:32], pc: pend_pc};
            end else begin
                enq_n = 2'd2;
                wr0   = '{inst: imem_data_i[31:0],  pc: pend_pc};
                wr1   = '{inst: imem_data_i[63:32], pc: pend_pc + 32'd4};
            end
        end
    end

    // Clamp decode's consumption to what is actually held.
    assign deq_n = ({{(CW-2){1'b0}}, issue_cnt_i} > count) ? count[1:0] : issue_cnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpc     <= RESET_PC;
            pend_pc <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pend    <= 1'b0;
        end else if (redirect_i) begin
            fpc   <= {redirect_pc_i[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pend  <= 1'b0;
        end else begin
            count <= count + CW'(enq_n) - CW'(deq_n);
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            pend  <= imem_req_o;
            if (imem_req_o) begin
                pend_pc <= fpc;
                fpc     <= {fpc[31:3], 3'b000} + 32'd8;
            end
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !redirect_i) begin
            if (enq_n != 2'd0) q_mem[tail]           <= wr0;
            if (enq_n == 2'd2) q_mem[tail + PW'(1)]  <= wr1;
        end
    end

    // Decode slot outputs, slot s shows the entry s places behind head.
    logic [1:0]       slot_vld;
    logic [1:0][31:0] slot_inst, slot_pc;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        fq_entry_t ent;
        assign ent          = q_mem[head + PW'(s)];
        assign slot_vld[s]  = count > CW'(s);
        assign slot_inst[s] = slot_vld[s] ? ent.inst : NOP;
        assign slot_pc[s]   = slot_vld[s] ? ent.pc   : 32'd0;
    end

    assign valid0_o = slot_vld[0];
    assign valid1_o = slot_vld[1];
    assign inst0_o  = slot_inst[0];
    assign inst1_o  = slot_inst[1];
    assign pc0_o    = slot_pc[0];
    assign pc1_o    = slot_pc[1];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [63:0] imem_data_i;
    logic [1:0]  issue_cnt_i;
    logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
    logic        valid0_o, valid1_o;

    always #5 clk_i = ~clk_i;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .issue_cnt_i(issue_cnt_i), .inst0_o(inst0_o), .inst1_o(inst1_o),
        .pc0_o(pc0_o), .pc1_o(pc1_o), .valid0_o(valid0_o), .valid1_o(valid1_o)
    );

    // Reference model: an ordered list of fetched (inst, pc) pairs plus the
    // fetch PC and the single outstanding request.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc, m_fpc;
    bit          live = 0;
    int          vectors = 0, miscompares = 0, proto_errs = 0;

    // Instruction memory contents: word k holds k+1.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input logic [1:0] iss);
        bit          exp_req, req_seen;
        logic [31:0] addr_seen, a;
        int          deq;
        rst_i = rst; redirect_i = redir; redirect_pc_i = rpc; issue_cnt_i = iss;
        #1;
        exp_req = !rst && !redir && (mq.size() + 2 * m_pend <= DEPTH - 2);
        if (live) begin
            check("valid0", valid0_o, mq.size() >= 1);
            check("valid1", valid1_o, mq.size() >= 2);
            if (mq.size() >= 1) begin
                check("inst0", inst0_o, mq[0].inst); check("pc0", pc0_o, mq[0].pc);
            end else begin
                check("inst0_nop", inst0_o, NOP); check("pc0_zero", pc0_o, 0);
            end
            if (mq.size() >= 2) begin
                check("inst1", inst1_o, mq[1].inst); check("pc1", pc1_o, mq[1].pc);
            end else begin
                check("inst1_nop", inst1_o, NOP); check("pc1_zero", pc1_o, 0);
            end
            check("req", imem_req_o, exp_req);
            check("addr", imem_addr_o, {m_fpc[31:3], 3'b000});
        end
        req_seen  = imem_req_o;
        addr_seen = imem_addr_o;
        if (rst) begin
            mq.delete(); m_pend = 0; m_fpc = RESET_PC; live = 1;
        end else if (redir) begin
            mq.delete(); m_pend = 0; m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (iss > mq.size()) proto_errs++;
            deq = (iss > mq.size()) ? mq.size() : int'(iss);
            repeat (deq) void'(mq.pop_front());
            if (m_pend) begin
                a = {m_pend_pc[31:3], 3'b000};
                if (!m_pend_pc[2]) begin
                    mq.push_back('{word(a), m_pend_pc});
                    mq.push_back('{word(a + 4), m_pend_pc + 4});
                end else begin
                    mq.push_back('{word(a + 4), m_pend_pc});
                end
            end
            if (exp_req) begin
                m_pend = 1; m_pend_pc = m_fpc; m_fpc = {m_fpc[31:3], 3'b000} + 8;
            end else begin
                m_pend = 0;
            end
            vectors++;
            assert (mq.size() <= DEPTH) else begin
                miscompares++;
                $error("FAIL overflow: model count %0d exceeds %0d", mq.size(), DEPTH);
            end
        end
        @(posedge clk_i); #1;
        // Synchronous memory: answer the request seen last cycle, junk otherwise.
        imem_data_i = req_seen ? {word(addr_seen + 4), word(addr_seen)} : {$urandom, $urandom};
    endtask

    initial begin
        int bubbles, p, r;
        bit rr, rd;
        logic [1:0] is;
        imem_data_i = '0;

        // Reset and start-up from RESET_PC with no consumption.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("start_inst0", inst0_o, 32'd1);
        check("start_pc0", pc0_o, 32'd0);
        check("start_inst1", inst1_o, 32'd2);
        check("start_pc1", pc1_o, 32'd4);
        repeat (8) step(0, 0, 0, 0);
        check("full_req_low", imem_req_o, 0);
        check("full_pc0", pc0_o, 32'd0);

        // Streaming dual issue, long enough to wrap the pointers several times.
        bubbles = 0;
        for (int i = 0; i < 48; i++) begin
            step(0, 0, 0, 2);
            if (i > 4 && !valid1_o) bubbles++;
        end
        check("stream_bubbles", bubbles, 0);

        // Misaligned redirect: fetch 0x100, keep only 0x104.
        step(0, 1, 32'h0000_0106, 0);
        check("redir_addr", imem_addr_o, 32'h0000_0100);
        check("redir_inval", valid0_o, 0);
        repeat (6) step(0, 0, 0, 0);
        check("mis_pc0", pc0_o, 32'h0000_0104);
        check("mis_pc1", pc1_o, 32'h0000_0108);

        // Redirect while a response is in flight.
        repeat (3) step(0, 0, 0, 2);
        step(0, 1, 32'h0000_0200, 2);
        check("flight_inval", valid0_o, 0);
        check("flight_addr", imem_addr_o, 32'h0000_0200);
        repeat (3) step(0, 0, 0, 0);

        // Clamp: one entry held, decode asks for two.
        step(0, 1, 32'h0000_0104, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        p = proto_errs;
        step(0, 0, 0, 2);
        check("clamp_flag", proto_errs - p, 1);
        check("clamp_pc0", pc0_o, 32'h0000_0108);

        // Reset mid-stream with five entries held.
        step(0, 1, 32'h0000_0104, 0);
        repeat (4) step(0, 0, 0, 0);
        check("five_pc0", pc0_o, 32'h0000_0104);
        step(1, 0, 0, 0);
        check("rst_valid0", valid0_o, 0);
        check("rst_req", imem_req_o, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        check("restart_pc0", pc0_o, RESET_PC);

        // Random traffic with occasional redirects, resets and over-issue.
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            rr = (r < 2);
            rd = (r >= 2 && r < 8);
            is = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(rr, rd, $urandom, is);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
